// File: rtl/fifo_read_drain.sv
// Read-side drain for the dual-clock FIFO: pops on credit, captures rdata one cycle
// after each pop into a 2-entry buffer, and streams the words out over valid/ready.
module fifo_read_drain #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             ren,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] drain_cnt,
  output logic             busy
);

  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic             head_q, head_d;
  logic [DSIZE-1:0] buf_q [2];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       deq;
  logic       cap;
  logic       wr_idx;
  logic [1:0] credits_used;

  assign deq = m_valid & m_ready;
  assign cap = inflight_q & ~flush;

  // Tail slot: with the head advancing in the same cycle at occ=1 this lands on the new head.
  assign wr_idx = head_q ^ occ_q[0];

  // occ + inflight never exceeds 2 and deq implies occ >= 1, so 2 bits cannot wrap.
  assign credits_used = occ_q + {1'b0, inflight_q} - {1'b0, deq};

  assign rinc = ~rst & ~flush & ~rempty & (credits_used < 2'd2);
  assign ren  = rinc;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_q[head_q];
  assign drain_cnt = cnt_q;
  assign busy      = (occ_q != 2'd0) | inflight_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      occ_d  = occ_q + {1'b0, cap} - {1'b0, deq};
      head_d = head_q ^ deq;
      cnt_d  = cnt_q + CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      cnt_q      <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rinc;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      if (cap) begin
        buf_q[wr_idx] <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_drain.sv
// Randomized bench for fifo_read_drain: a queue-based FIFO source and a scoreboard of
// popped-but-undelivered words predict every output cycle by cycle.
module tb_fifo_read_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rempty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;

  logic        rinc, ren, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] drain_cnt;
  logic        rinc4, ren4, m_valid4, busy4;
  logic [7:0]  m_data4;
  logic [3:0]  drain_cnt4;

  fifo_read_drain #(.DSIZE(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .ren(ren), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .flush(flush), .drain_cnt(drain_cnt), .busy(busy)
  );

  fifo_read_drain #(.DSIZE(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata),
    .rinc(rinc4), .ren(ren4), .m_valid(m_valid4), .m_data(m_data4),
    .m_ready(m_ready), .flush(flush), .drain_cnt(drain_cnt4), .busy(busy4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    int         stamp;
  } pend_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  src[$];
  pend_t       pend[$];
  int          edge_n = 0;
  logic [15:0] cnt_m = 16'd0;
  int          xfers = 0;
  logic [7:0]  last_xfer = 8'h00;
  logic        last_popped = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) src.push_back(first + 8'(i));
    rempty = (src.size() == 0);
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic       vexp, hs, rinc_s, flush_s, rst_s;
    logic [7:0] w;
    @(negedge clk);
    vexp = (pend.size() != 0) && (pend[0].stamp <= edge_n - 1);
    hs   = vexp & m_ready;
    chk("m_valid", 32'(m_valid), 32'(vexp));
    if (vexp) chk("m_data", 32'(m_data), 32'(pend[0].w));
    chk("busy", 32'(busy), 32'(pend.size() != 0));
    chk("rinc", 32'(rinc), 32'(!rst && !flush && !rempty && (pend.size() - int'(hs) < 2)));
    chk("ren", 32'(ren), 32'(rinc));
    chk("drain_cnt", 32'(drain_cnt), 32'(cnt_m));
    chk("drain_cnt4", 32'(drain_cnt4), 32'(cnt_m[3:0]));
    chk("no_overflow", 32'(pend.size() <= 2), 32'd1);
    rinc_s  = rinc;
    flush_s = flush;
    rst_s   = rst;
    @(posedge clk);
    edge_n++;
    last_popped = 1'b0;
    if (rst_s) begin
      pend.delete();
      cnt_m = 16'd0;
    end else if (flush_s) begin
      pend.delete();
    end else if (hs) begin
      $display("xfer n=%0d data=%02h", cnt_m, pend[0].w);
      last_xfer = pend[0].w;
      xfers++;
      void'(pend.pop_front());
      cnt_m++;
    end
    if (rinc_s && src.size() != 0) begin
      w = src.pop_front();
      if (!rst_s) begin
        pend.push_back('{w, edge_n});
        last_popped = 1'b1;
      end
      #1 rdata = w;
    end else begin
      #1;
    end
    rempty = (src.size() == 0);
  endtask

  task automatic run_idle(input int bound);
    int n = 0;
    while ((src.size() != 0 || pend.size() != 0) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int x0;
    // Reset with an empty FIFO and ready held high.
    rst = 1'b1; m_ready = 1'b1;
    step(); step();
    chk("rst_m_data", 32'(m_data), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t1_cnt", 32'(drain_cnt), 32'd0);

    // Eight words streamed with continuous ready.
    load(8'h11, 8);
    run_idle(40);
    step();
    chk("t2_cnt", 32'(drain_cnt), 32'd8);
    chk("t2_busy", 32'(busy), 32'd0);

    // Backpressure: two pops then hold, head word stable.
    m_ready = 1'b0;
    load(8'h11, 8);
    for (int i = 0; i < 8; i++) step();
    chk("t3_src_left", 32'(src.size()), 32'd6);
    chk("t3_hold_valid", 32'(m_valid), 32'd1);
    chk("t3_hold_data", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    run_idle(40);
    chk("t3_cnt", 32'(drain_cnt), 32'd16);

    // Alternating ready, then random ready / refill / occasional flush.
    load(8'h40, 12);
    for (int i = 0; i < 40; i++) begin
      m_ready = ~i[0];
      step();
    end
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 2) == 0 && src.size() < 12) src.push_back(8'($urandom));
      rempty = (src.size() == 0);
      step();
    end
    flush = 1'b0; m_ready = 1'b1;
    run_idle(60);

    // Flush with two buffered words and nothing in flight.
    m_ready = 1'b0;
    load(8'h21, 4);
    for (int i = 0; i < 4; i++) step();
    chk("t5_pre_occ2", 32'(pend.size() == 2 && pend[1].stamp <= edge_n - 1), 32'd1);
    x0 = int'(cnt_m);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnt", 32'(drain_cnt), 32'(x0));
    m_ready = 1'b1;
    x0 = xfers;
    n = 0;
    while (xfers == x0 && n < 20) begin step(); n++; end
    chk("t5_next_word", 32'(last_xfer), 32'h23);
    run_idle(40);

    // Reset asserted while a pop is in flight.
    load(8'h60, 4);
    n = 0;
    while (!last_popped && n < 10) begin step(); n++; end
    chk("t6_inflight", 32'(last_popped), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rinc", 32'(rinc), 32'd0);
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_data", 32'(m_data), 32'd0);
    chk("t6_cnt", 32'(drain_cnt), 32'd0);
    pend.delete();
    cnt_m = 16'd0;
    step();
    rst = 1'b0;
    src.delete();
    rempty = 1'b1;
    step();

    // 17 transfers wrap a 4-bit counter to 1.
    load(8'h80, 17);
    run_idle(60);
    step();
    chk("t6_wrap4", 32'(drain_cnt4), 32'd1);
    chk("t6_cnt17", 32'(drain_cnt), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_read_drain.md
Name: fifo_read_drain

Overview:
Read-side consumer for the team's dual-clock FIFO. It lives entirely in the read clock domain. It watches the FIFO empty flag, issues pops (rinc/ren), and captures the FIFO read data one cycle after each pop. The captured words go into a 2-entry output buffer and leave through a valid/ready stream. A delivered-word counter and a flush control support draining and test.

Parameters:
DSIZE, 8, data width; matches the FIFO DSIZE.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  input  1  read-domain clock; the same net as the FIFO rclk.
rst  input  1  asynchronous, active-high reset.
rempty  input  1  FIFO read-empty flag.
rdata  input  DSIZE  FIFO read data; valid on the cycle after a pop.
rinc  output  1  FIFO read-pointer increment (pop).
ren  output  1  FIFO memory read enable; always equal to rinc.
m_valid  output  1  output word valid.
m_data  output  DSIZE  output word.
m_ready  input  1  downstream accepts the word.
flush  input  1  discard buffered and in-flight data for one cycle.
drain_cnt  output  CNT_W  count of words accepted downstream.
busy  output  1  buffer non-empty or a pop is in flight.

Behaviour:
- Reset (async assert, released on a clk edge): rinc=0, ren=0, m_valid=0, m_data=0, drain_cnt=0, busy=0, buffer empty, inflight=0.
- State:
  - occ: 0..2, number of buffered words.
  - inflight: 1 bit, set in the cycle after a pop.
  - head/tail: 2-entry register array used in FIFO order.
- Pop rule (combinational): rinc = !rst & !flush & !rempty & (occ + inflight - deq < 2).
  - deq = m_valid & m_ready in the current cycle, so a same-cycle dequeue frees a credit.
  - A pop is never issued while rempty=1; rempty is trusted as registered and exact in this domain.
- Pop latency: a pop at edge t sets inflight at t+1. At edge t+2 rdata (stable during cycle t+1) is written to the buffer tail.
  - With continuous ready and a non-empty FIFO, m_valid first rises 2 cycles after the first rinc.
  - Throughput is then 1 word per cycle.
- Output: m_valid = (occ != 0); m_data = head entry.
  - m_data holds while m_valid & !m_ready (standard valid/ready stability).
- Simultaneous capture and dequeue at occ=1: the head advances to the newly captured word, occ stays 1.
- Simultaneous capture and dequeue at occ=2 cannot occur, because the credit rule forbids it.
- Overflow (occ=2 with inflight=1) is impossible by construction; the bench asserts it never happens.
- flush=1 at an edge:
  - occ→0 and inflight→0.
  - The in-flight rdata word is dropped.
  - m_valid=0 the next cycle.
  - rinc is forced 0 during the flush cycle.
  - drain_cnt is unchanged, and a dequeue in the flush cycle is not counted.
  - Words already popped are lost; the FIFO pointers are not rewound.
- drain_cnt: increments by 1 on each accepted transfer (m_valid & m_ready & !flush) and wraps modulo 2^CNT_W.
- busy = (occ != 0) | inflight.
- Reset mid-operation: everything returns immediately to reset values.
  - Any word in flight is lost.
  - rinc drops in the same cycle because the reset term is combinational.

Test Plan:
1. Reset, rempty=1, m_ready=1 for 10 cycles → rinc never asserts; m_valid=0, drain_cnt=0, busy=0.
2. FIFO preloaded with 0x11..0x18 (rempty drops, rises after the 8th pop), m_ready=1:
   - first m_valid exactly 2 cycles after the first rinc;
   - outputs 0x11..0x18 in order on consecutive cycles;
   - drain_cnt=8, then busy=0.
3. Same 8 words with m_ready=0:
   - exactly 2 pops then rinc=0; m_valid=1, m_data=0x11 held stable;
   - release ready → remaining words in order, none lost or duplicated.
4. m_ready toggled 1,0,1,0… with a non-empty FIFO → output order preserved, no overflow assertion, drain_cnt equals the number of handshakes.
5. flush pulsed while occ=2 and inflight=0, on the words 0x21, 0x22:
   - next cycle m_valid=0, busy=0, drain_cnt unchanged;
   - the next pop delivers 0x23.
6. CNT_W=4 run with 17 transfers → drain_cnt reads 1. Separately, assert rst while inflight=1 → all outputs 0 immediately, rinc=0 in the same cycle.
